// File: rtl/blowfish_round_ctrl.sv
// Blowfish round sequencer.
// Walks one 64-bit block through 16 Feistel rounds using an external P-array
// store (combinational read) and a shared F-function ROM with F_LAT edges of
// latency, then applies the two output whitening steps and reports the result
// through a start/busy/done handshake.
module blowfish_round_ctrl #(
  parameter int F_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] din,
  output logic [4:0]  p_idx,
  input  logic [31:0] p_data,
  output logic [31:0] f_in,
  input  logic [31:0] f_out,
  output logic        busy,
  output logic        done,
  output logic [63:0] dout
);

  typedef enum logic [2:0] {
    s_idle,
    s_xorp,
    s_wait,
    s_mix,
    s_fin1,
    s_fin2
  } state_t;

  // Last value of the wait counter before the ROM result is usable.
  localparam logic [2:0] WCNT_LAST = 3'(F_LAT - 1);

  state_t      state;
  state_t      state_nxt;

  logic [31:0] l_q;
  logic [31:0] r_q;
  logic [3:0]  rnd;
  logic [2:0]  wcnt;
  logic        dec_q;

  logic [31:0] l_nxt;
  logic [31:0] r_nxt;
  logic [3:0]  rnd_nxt;
  logic [2:0]  wcnt_nxt;
  logic        dec_nxt;
  logic [31:0] f_in_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic [63:0] dout_nxt;

  // Round subkey: encryption walks P[0..15], decryption walks P[17..2].
  function automatic logic [4:0] round_key(input logic [3:0] r, input logic dec);
    logic [4:0] ke;
    ke = {1'b0, r};
    return dec ? (5'd17 - ke) : ke;
  endfunction

  // Output whitening subkeys: first step P[16]/P[1], second step P[17]/P[0].
  function automatic logic [4:0] final_key(input logic second, input logic dec);
    logic [4:0] ke;
    if (second) ke = dec ? 5'd0 : 5'd17;
    else        ke = dec ? 5'd1 : 5'd16;
    return ke;
  endfunction

  // State register; reset abandons any block in flight.
  always_ff @(posedge clk) begin
    if (!rst) state <= s_idle;
    else      state <= state_nxt;
  end

  // Half-block, counters, ROM operand and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      l_q   <= '0;
      r_q   <= '0;
      rnd   <= '0;
      wcnt  <= '0;
      dec_q <= 1'b0;
      f_in  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
    end else begin
      l_q   <= l_nxt;
      r_q   <= r_nxt;
      rnd   <= rnd_nxt;
      wcnt  <= wcnt_nxt;
      dec_q <= dec_nxt;
      f_in  <= f_in_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      dout  <= dout_nxt;
    end
  end

  // Next-state, next-register values and the P-array index for each state.
  always_comb begin
    state_nxt = state;
    l_nxt     = l_q;
    r_nxt     = r_q;
    rnd_nxt   = rnd;
    wcnt_nxt  = wcnt;
    dec_nxt   = dec_q;
    f_in_nxt  = f_in;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    dout_nxt  = dout;
    p_idx     = 5'd0;

    case (state)
      s_idle: begin
        if (start) begin
          l_nxt     = din[63:32];
          r_nxt     = din[31:0];
          dec_nxt   = decrypt;
          rnd_nxt   = 4'd0;
          busy_nxt  = 1'b1;
          state_nxt = s_xorp;
        end
      end

      s_xorp: begin
        // The whitened left half is both kept and sent to the ROM; f_in is
        // only written here so it stays stable while the ROM works.
        p_idx     = round_key(rnd, dec_q);
        l_nxt     = l_q ^ p_data;
        f_in_nxt  = l_q ^ p_data;
        wcnt_nxt  = 3'd0;
        state_nxt = s_wait;
      end

      s_wait: begin
        wcnt_nxt = wcnt + 3'd1;
        if (wcnt == WCNT_LAST) state_nxt = s_mix;
      end

      s_mix: begin
        // Fold F(L) into R and swap halves.
        l_nxt = r_q ^ f_out;
        r_nxt = l_q;
        if (rnd == 4'd15) begin
          state_nxt = s_fin1;
        end else begin
          rnd_nxt   = rnd + 4'd1;
          state_nxt = s_xorp;
        end
      end

      s_fin1: begin
        // Undo the last swap and whiten the right half.
        p_idx     = final_key(1'b0, dec_q);
        l_nxt     = r_q;
        r_nxt     = l_q ^ p_data;
        state_nxt = s_fin2;
      end

      s_fin2: begin
        p_idx     = final_key(1'b1, dec_q);
        dout_nxt  = {l_q ^ p_data, r_q};
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = s_idle;
      end

      default: begin
        state_nxt = s_idle;
      end
    endcase
  end

endmodule

// File: tb/tb_blowfish_round_ctrl.sv
// Bench for blowfish_round_ctrl: one instance with F_LAT=1 and one with
// F_LAT=3, each with its own P-array store and pipelined ROM stub, checked
// every cycle against a transaction-level Blowfish model plus literal values.
module tb_blowfish_round_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [63:0] din;

  logic [4:0]  p_idx_a, p_idx_b;
  logic [31:0] p_data_a, p_data_b;
  logic [31:0] f_in_a, f_in_b, f_out_a, f_out_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [63:0] dout_a, dout_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rom_mode = 0;
  bit pz = 1'b1;
  bit chk_en = 1'b0;

  // model state, index 0 = F_LAT 1, index 1 = F_LAT 3
  bit          m_act [2];
  int          m_t [2];
  bit          m_dec [2];
  logic        m_busy [2];
  logic        m_done [2];
  logic [63:0] m_dout [2];
  logic [63:0] m_res [2];
  logic [31:0] m_fin [2];
  logic [31:0] m_fv [2][16];

  int ptrace[$];
  int taq[$];
  int tbq[$];

  logic [31:0] rom_a = '0, rom_b0 = '0, rom_b1 = '0, rom_b2 = '0;

  int e, la, lb, cnt_a, errs;
  logic [63:0] da, db, ref_ct;
  logic [63:0] d0 = 64'h01234567_89ABCDEF;

  always #5 clk = ~clk;

  blowfish_round_ctrl #(.F_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .din(din),
    .p_idx(p_idx_a), .p_data(p_data_a), .f_in(f_in_a), .f_out(f_out_a),
    .busy(busy_a), .done(done_a), .dout(dout_a)
  );

  blowfish_round_ctrl #(.F_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .din(din),
    .p_idx(p_idx_b), .p_data(p_data_b), .f_in(f_in_b), .f_out(f_out_b),
    .busy(busy_b), .done(done_b), .dout(dout_b)
  );

  function automatic logic [31:0] pinit(input int k);
    case (k)
      0: return 32'h243F6A88;  1: return 32'h85A308D3;  2: return 32'h13198A2E;
      3: return 32'h03707344;  4: return 32'hA4093822;  5: return 32'h299F31D0;
      6: return 32'h082EFA98;  7: return 32'hEC4E6C89;  8: return 32'h452821E6;
      9: return 32'h38D01377; 10: return 32'hBE5466CF; 11: return 32'h34E90C6C;
     12: return 32'hC0AC29B7; 13: return 32'hC97C50DD; 14: return 32'h3F84D5B5;
     15: return 32'hB5470917; 16: return 32'h9216D5D9; 17: return 32'h8979FB1B;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] pget(input int k);
    return pz ? 32'h0 : pinit(k);
  endfunction

  function automatic logic [31:0] sbox(input int n, input logic [7:0] x);
    logic [31:0] v;
    v = ({24'd0, x} + 32'(n) * 32'd257 + 32'd1) * 32'h9E3779B1;
    v = v ^ (v >> 15);
    v = v * 32'h85EBCA6B;
    v = v ^ (v >> 13);
    return v;
  endfunction

  function automatic logic [31:0] ffun(input logic [31:0] x);
    case (rom_mode)
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      default: return ((sbox(0, x[31:24]) + sbox(1, x[23:16])) ^ sbox(2, x[15:8])) + sbox(3, x[7:0]);
    endcase
  endfunction

  // Plain Blowfish on one block; i >= 0 also records the ROM operands.
  function automatic logic [63:0] feistel(input logic [63:0] d, input bit dec, input int i);
    logic [31:0] l, r, t;
    int k;
    l = d[63:32];
    r = d[31:0];
    for (int n = 0; n < 16; n++) begin
      k = dec ? 17 - n : n;
      l = l ^ pget(k);
      if (i >= 0) m_fv[i][n] = l;
      t = r ^ ffun(l);
      r = l;
      l = t;
    end
    return {r ^ pget(dec ? 0 : 17), l ^ pget(dec ? 1 : 16)};
  endfunction

  function automatic int flat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [4:0] exp_pidx(input int i);
    int per, t, r;
    per = flat(i) + 2;
    t = m_t[i];
    if (!m_act[i]) return 5'd0;
    if (t < 16 * per) begin
      r = t / per;
      if (t % per == 0) return m_dec[i] ? 5'(17 - r) : 5'(r);
      return 5'd0;
    end
    if (t == 16 * per) return m_dec[i] ? 5'd1 : 5'd16;
    return m_dec[i] ? 5'd0 : 5'd17;
  endfunction

  assign p_data_a = pget(int'(p_idx_a));
  assign p_data_b = pget(int'(p_idx_b));
  assign f_out_a  = rom_a;
  assign f_out_b  = rom_b2;

  // ROM stubs: one and three register stages.
  always @(posedge clk) begin
    rom_a  <= ffun(f_in_a);
    rom_b0 <= ffun(f_in_b);
    rom_b1 <= rom_b0;
    rom_b2 <= rom_b1;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_inst(input int i, input logic bz, input logic dn, input logic [63:0] dq,
                          input logic [31:0] fi, input logic [4:0] pi);
    check($sformatf("busy%0d", i), bz, m_busy[i]);
    check($sformatf("done%0d", i), dn, m_done[i]);
    check($sformatf("dout%0d", i), dq, m_dout[i]);
    check($sformatf("f_in%0d", i), fi, m_fin[i]);
    check($sformatf("p_idx%0d", i), pi, exp_pidx(i));
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_act[i] = 0; m_t[i] = 0; m_busy[i] = 0; m_done[i] = 0;
        m_dout[i] = '0; m_fin[i] = '0;
      end else begin
        m_done[i] = 0;
        if (!m_act[i]) begin
          if (start) begin
            m_act[i] = 1; m_t[i] = 0; m_busy[i] = 1; m_dec[i] = decrypt;
            m_res[i] = feistel(din, decrypt, i);
          end
        end else begin
          m_t[i]++;
          if ((m_t[i] - 1) % (flat(i) + 2) == 0 && (m_t[i] - 1) / (flat(i) + 2) < 16)
            m_fin[i] = m_fv[i][(m_t[i] - 1) / (flat(i) + 2)];
          if (m_t[i] == 16 * (flat(i) + 2) + 2) begin
            m_done[i] = 1; m_busy[i] = 0; m_dout[i] = m_res[i]; m_act[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic go(input logic [63:0] d, input bit dec, output int eo);
    @(negedge clk);
    start = 1'b1; din = d; decrypt = dec;
    @(negedge clk);
    start = 1'b0;
    eo = cyc;
    ptrace.delete();
    if (p_idx_a != 5'd0) ptrace.push_back(int'(p_idx_a));
  endtask

  task automatic wait_done(input int eo, output int lao, output int lbo,
                           output logic [63:0] dao, output logic [63:0] dbo);
    lao = -1; lbo = -1; dao = '0; dbo = '0;
    for (int n = 0; n < 120 && (lao < 0 || lbo < 0); n++) begin
      @(negedge clk);
      if (lao < 0 && p_idx_a != 5'd0) ptrace.push_back(int'(p_idx_a));
      if (done_a && lao < 0) begin lao = cyc - eo; dao = dout_a; end
      if (done_b && lbo < 0) begin lbo = cyc - eo; dbo = dout_b; end
    end
    if (lao < 0 || lbo < 0) check("done_timeout", {32'(lao), 32'(lbo)}, 64'h0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_a || busy_b) && n < 200) begin @(negedge clk); n++; end
    if (busy_a || busy_b) check("idle_timeout", {busy_a, busy_b}, 64'h0);
  endtask

  task automatic check_trace(input string nm, input bit dec);
    errs = 0;
    check({nm, "_len"}, ptrace.size(), 17);
    for (int n = 0; n < ptrace.size() && n < 17; n++)
      if (ptrace[n] != (dec ? 17 - n : n + 1)) errs++;
    check(nm, errs, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; decrypt = 1'b0; din = '0;
    fork
      forever begin
        @(posedge clk);
        cyc++;
        model_step();
      end
      forever begin
        @(negedge clk);
        if (chk_en) begin
          cmp_inst(0, busy_a, done_a, dout_a, f_in_a, p_idx_a);
          cmp_inst(1, busy_b, done_b, dout_b, f_in_b, p_idx_b);
        end
      end
    join_none

    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_dout", dout_a, 64'h0);
    check("rst_f_in", f_in_b, 32'h0);
    rst = 1'b1;

    // zero P, zero F
    pz = 1'b1; rom_mode = 0;
    go(d0, 1'b0, e);
    wait_done(e, la, lb, da, db);
    check("zero_lat1", la, 50);
    check("zero_lat3", lb, 82);
    check("zero_dout1", da, 64'h89ABCDEF_01234567);
    check("zero_dout3", db, 64'h89ABCDEF_01234567);

    // zero P, all-ones F
    wait_idle();
    rom_mode = 1;
    go(d0, 1'b0, e);
    wait_done(e, la, lb, da, db);
    check("ones_dout1", da, 64'h89ABCDEF_01234567);
    check("ones_dout3", db, 64'h89ABCDEF_01234567);

    // real P-array, nonlinear F, round trip
    wait_idle();
    rom_mode = 2; pz = 1'b0;
    ref_ct = feistel(d0, 1'b0, -1);
    go(d0, 1'b0, e);
    wait_done(e, la, lb, da, db);
    check_trace("ptrace_enc", 1'b0);
    check("enc_dout1", da, ref_ct);
    check("enc_dout3", db, ref_ct);
    check("enc_lat3", lb, 82);
    wait_idle();
    go(da, 1'b1, e);
    wait_done(e, la, lb, da, db);
    check_trace("ptrace_dec", 1'b1);
    check("dec_dout1", da, d0);
    check("dec_dout3", db, d0);

    // start pulses while busy are ignored
    wait_idle();
    go(d0, 1'b0, e);
    cnt_a = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done_a) cnt_a++;
      if (cyc - e == 4 || cyc - e == 39) begin start = 1'b1; din = ~d0; decrypt = 1'b1; end
      else start = 1'b0;
    end
    start = 1'b0;
    check("ign_done_cnt", cnt_a, 1);
    check("ign_dout1", dout_a, ref_ct);
    wait_idle();
    check("ign_dout3", dout_b, ref_ct);

    // start held high: back-to-back blocks
    @(negedge clk);
    start = 1'b1; din = d0; decrypt = 1'b0;
    for (int n = 0; n < 300 && tbq.size() < 2; n++) begin
      @(negedge clk);
      if (done_a) taq.push_back(cyc);
      if (done_b) tbq.push_back(cyc);
    end
    start = 1'b0;
    check("held_gap1", (taq.size() >= 2) ? taq[1] - taq[0] : -1, 51);
    check("held_gap3", (tbq.size() >= 2) ? tbq[1] - tbq[0] : -1, 83);
    wait_idle();

    // reset in round 7
    go(d0, 1'b0, e);
    while (cyc - e < 22) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_dout", dout_a, 64'h0);
    check("abort_f_in", f_in_a, 32'h0);
    check("abort_busy3", busy_b, 0);
    rst = 1'b1;
    go(d0, 1'b0, e);
    wait_done(e, la, lb, da, db);
    check("post_lat1", la, 50);
    check("post_dout1", da, ref_ct);
    check("post_dout3", db, ref_ct);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
